mda_motor_control_bridge_drive: RTL and testbench
=================================================

Name: mda_motor_control_bridge_drive

Overview:
- Sits directly downstream of the per-motor PWM generator and consumes its dir_reg/on_reg pair each clock.
- Decodes the pair into the four H-bridge gate drives: high-side A, low-side A, high-side B, low-side B.
- Inserts programmable dead time wherever a transition could cause shoot-through in a bridge leg.
- Passes shoot-through-free transitions (into or out of drift) without added delay.

Parameters:
- DEAD_CYCLES, 16, dead-time length in clk cycles (1 us at 16 MHz); legal range 1..255.
- CNT_WIDTH, 8, width of the dead-time counter; must hold DEAD_CYCLES-1.

Ports:
- clk  in  1  system clock, the same clock as the PWM generator.
- reset  in  1  synchronous, active-high reset.
- dir_reg  in  1  direction/brake select from the PWM generator.
- on_reg  in  1  drive-enable from the PWM generator.
- gates  out  4  {hi_a, lo_a, hi_b, lo_b}, registered, active-high transistor enables.
- dead_active  out  1  high while a dead-time interval is in progress.
- overrun  out  1  sticky; set when the request changes during dead time; cleared only by reset.

Behaviour:
- Decode of request (on_reg, dir_reg) to a target gate vector:
  - 00, drift: 0000.
  - 01, brake: 0101 (both low sides).
  - 11, forward: 1001 (hi_a, lo_b).
  - 10, reverse: 0110 (lo_a, hi_b).
- Input stage: on_reg/dir_reg are registered into req_q at every posedge. All decisions use req_q.
- Internal state: applied (the current gate vector), target, a dead counter, and an FSM with states HOLD and DEAD.
- Conflict rule: a change from applied to target needs dead time iff, in some leg, one gate turns on while the other gate of that leg is currently on.
  - Leg A conflict: (target.hi_a & applied.lo_a) | (target.lo_a & applied.hi_a).
  - Leg B is the same with hi_b/lo_b.
- HOLD, target == applied: no action.
- HOLD, target != applied, no conflict: gates <= target on the next edge. Latency from the input change to the gates is 2 clk edges.
- HOLD, target != applied, conflict:
  - gates <= applied & target (the gates common to both vectors stay on; all others go off).
  - Counter <= DEAD_CYCLES-1; dead_active <= 1; go to DEAD.
- DEAD, counter != 0 and target unchanged: decrement the counter; gates held.
- DEAD, counter == 0:
  - gates <= target; applied <= target; dead_active <= 0; go to HOLD.
  - The dead interval is therefore exactly DEAD_CYCLES cycles.
- DEAD, req_q decodes to a new target:
  - Latch the new target; gates <= gates & new_target (gates may only turn off, never on).
  - Reload counter <= DEAD_CYCLES-1; overrun <= 1.
- Invariant: hi_a&lo_a and hi_b&lo_b are never both 1 on any cycle, including reset exit and mid-dead changes.
- Reset values:
  - gates = 0000 (drift); applied = 0000; req_q = 00.
  - dead_active = 0; overrun = 0; FSM in HOLD.
- Reset asserted mid-DEAD: outputs go to the reset values on that edge; no residual count survives.
- Back-to-back non-conflicting changes, e.g. drift→forward→drift on consecutive cycles: each is reflected 2 edges after its input change; no dead time.
- Continuous PWM between forward and brake (the normal generator pattern): every edge crosses leg A, so each transition takes DEAD_CYCLES cycles with lo_b held on throughout.

Test Plan (DEAD_CYCLES=4):
- Reset 3 cycles, then release with inputs 00 → gates=0000, dead_active=0, overrun=0 throughout.
- Inputs 00→11 at cycle 10 → gates=1001 after edge 12; dead_active stays 0.
- Forward (1001) steady, then inputs→01 (brake) → gates=0001 for exactly 4 cycles with dead_active=1, then 0101; leg A is never 11.
- Forward steady, then inputs→10 (reverse) → gates=0000 for 4 cycles, then 0110. Then →11 at dead cycle 2 → overrun=1, counter restarts, gates stay 0000 for 4 more cycles, then 1001.
- Forward steady, then reset asserted during DEAD → gates=0000, dead_active=0, overrun=0 on the edge after reset is sampled.
- Random on_reg/dir_reg toggling for 10k cycles → assertion monitor confirms no leg ever has both gates high, and every conflicting transition shows ≥4 all-off cycles on the affected leg.

Source files
------------

// File: rtl/mda_motor_control_bridge_drive.sv
// H-bridge gate driver for one motor channel.
// Turns the PWM generator's (on_reg, dir_reg) request into the four bridge
// gate enables {hi_a, lo_a, hi_b, lo_b}. Dead time is inserted only where a
// leg would otherwise switch one transistor on while its partner is still
// on. Changes that cannot cause shoot-through, such as entering or leaving
// drift, pass through with no added delay.
module mda_motor_control_bridge_drive #(
  parameter int DEAD_CYCLES = 16,
  parameter int CNT_WIDTH   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       dir_reg,
  input  logic       on_reg,
  output logic [3:0] gates,
  output logic       dead_active,
  output logic       overrun
);

  typedef enum logic {
    HOLD = 1'b0,
    DEAD = 1'b1
  } state_t;

  // Gate vector bit positions.
  localparam int HI_A = 3;
  localparam int LO_A = 2;
  localparam int HI_B = 1;
  localparam int LO_B = 0;

  // Reload value for the dead counter. The count runs down to zero, so the
  // interval spans exactly DEAD_CYCLES clocks.
  localparam logic [CNT_WIDTH-1:0] CNT_LOAD = CNT_WIDTH'(DEAD_CYCLES - 1);

  // Convert a request {on, dir} into a target gate vector.
  function automatic logic [3:0] decode_req(input logic [1:0] req);
    logic [3:0] g;
    case (req)
      2'b00:   g = 4'b0000;  // drift: every gate off
      2'b01:   g = 4'b0101;  // brake: both low sides on
      2'b11:   g = 4'b1001;  // forward: hi_a and lo_b
      default: g = 4'b0110;  // reverse: lo_a and hi_b
    endcase
    return g;
  endfunction

  // Return 1 when moving from cur to nxt would switch on a gate whose partner
  // in the same leg is currently on.
  function automatic logic leg_conflict(input logic [3:0] cur,
                                        input logic [3:0] nxt);
    logic leg_a;
    logic leg_b;
    leg_a = (nxt[HI_A] & cur[LO_A]) | (nxt[LO_A] & cur[HI_A]);
    leg_b = (nxt[HI_B] & cur[LO_B]) | (nxt[LO_B] & cur[HI_B]);
    return leg_a | leg_b;
  endfunction

  logic [1:0]           req_q;
  state_t               state_q,   state_d;
  logic [3:0]           gates_q,   gates_d;
  logic [3:0]           applied_q, applied_d;
  logic [3:0]           target_q,  target_d;
  logic [CNT_WIDTH-1:0] cnt_q,     cnt_d;
  logic                 overrun_q, overrun_d;
  logic [3:0]           req_tgt;

  // Gate vector requested by the registered input.
  assign req_tgt = decode_req(req_q);

  // Register the request and all bridge state. Reset forces drift and
  // discards any dead interval that is in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_q     <= 2'b00;
      state_q   <= HOLD;
      gates_q   <= 4'b0000;
      applied_q <= 4'b0000;
      target_q  <= 4'b0000;
      cnt_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      req_q     <= {on_reg, dir_reg};
      state_q   <= state_d;
      gates_q   <= gates_d;
      applied_q <= applied_d;
      target_q  <= target_d;
      cnt_q     <= cnt_d;
      overrun_q <= overrun_d;
    end
  end

  // Next-state logic. During dead time the gate vector may only lose bits,
  // so a request that changes mid-interval can never switch a gate on early.
  always_comb begin
    state_d   = state_q;
    gates_d   = gates_q;
    applied_d = applied_q;
    target_d  = target_q;
    cnt_d     = cnt_q;
    overrun_d = overrun_q;

    case (state_q)
      HOLD: begin
        if (req_tgt != applied_q) begin
          target_d = req_tgt;
          if (leg_conflict(applied_q, req_tgt)) begin
            // Keep only the gates common to both vectors and start dead time.
            gates_d = applied_q & req_tgt;
            cnt_d   = CNT_LOAD;
            state_d = DEAD;
          end else begin
            gates_d   = req_tgt;
            applied_d = req_tgt;
          end
        end
      end

      DEAD: begin
        if (req_tgt != target_q) begin
          // Retarget: drop any gate the new vector does not share, then
          // restart the full interval.
          target_d  = req_tgt;
          gates_d   = gates_q & req_tgt;
          cnt_d     = CNT_LOAD;
          overrun_d = 1'b1;
        end else if (cnt_q == '0) begin
          gates_d   = target_q;
          applied_d = target_q;
          state_d   = HOLD;
        end else begin
          cnt_d = cnt_q - CNT_WIDTH'(1);
        end
      end
    endcase
  end

  assign gates       = gates_q;
  assign dead_active = (state_q == DEAD);
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_mda_motor_control_bridge_drive.sv
// Directed and randomized bench for the H-bridge gate driver (DEAD_CYCLES=4).
module tb_mda_motor_control_bridge_drive;

  logic       clk = 1'b0;
  logic       reset;
  logic       dir_reg;
  logic       on_reg;
  logic [3:0] gates;
  logic       dead_active;
  logic       overrun;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mda_motor_control_bridge_drive #(
    .DEAD_CYCLES(4),
    .CNT_WIDTH  (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .dir_reg    (dir_reg),
    .on_reg     (on_reg),
    .gates      (gates),
    .dead_active(dead_active),
    .overrun    (overrun)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic set_req(input logic [1:0] r);
    on_reg  = r[1];
    dir_reg = r[0];
  endtask

  task automatic legs(input string tag);
    check({tag, "_legA"}, 32'(gates[3] & gates[2]), 32'd0);
    check({tag, "_legB"}, 32'(gates[1] & gates[0]), 32'd0);
  endtask

  task automatic expect_out(input string tag, input logic [3:0] g,
                            input logic d, input logic o);
    check({tag, "_gates"}, 32'(gates), 32'(g));
    check({tag, "_dead"}, 32'(dead_active), 32'(d));
    check({tag, "_ovr"}, 32'(overrun), 32'(o));
    legs(tag);
  endtask

  // Per-leg monitor: never both gates on. A gate that takes over from its
  // partner must follow at least 4 samples with the whole leg off.
  task automatic leg_mon(input string tag, input logic hi, input logic lo,
                         inout logic [1:0] last, inout int off);
    check({tag, "_both"}, 32'(hi & lo), 32'd0);
    if (hi | lo) begin
      if (last != 2'b00 && last != {hi, lo})
        check({tag, "_deadrun"}, 32'(off >= 4), 32'd1);
      last = {hi, lo};
      off  = 0;
    end else begin
      off++;
    end
  endtask

  initial begin
    logic [1:0] r;
    logic [1:0] last_a;
    logic [1:0] last_b;
    int         off_a;
    int         off_b;
    int         cyc;
    int         hold;

    reset = 1'b1;
    set_req(2'b00);
    repeat (3) begin
      step();
      expect_out("rst", 4'b0000, 1'b0, 1'b0);
    end
    reset = 1'b0;
    repeat (6) begin
      step();
      expect_out("idle", 4'b0000, 1'b0, 1'b0);
    end

    // Drift to forward: no conflict, two-edge latency.
    set_req(2'b11);
    step(); expect_out("fwd_lat", 4'b0000, 1'b0, 1'b0);
    step(); expect_out("fwd", 4'b1001, 1'b0, 1'b0);
    step(); expect_out("fwd_hold", 4'b1001, 1'b0, 1'b0);

    // Forward to brake: leg A conflicts, lo_b stays on.
    set_req(2'b01);
    step(); expect_out("brk_lat", 4'b1001, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(); expect_out("brk_dead", 4'b0001, 1'b1, 1'b0);
    end
    step(); expect_out("brk", 4'b0101, 1'b0, 1'b0);

    // Brake back to forward.
    set_req(2'b11);
    for (int i = 0; i < 5; i++) begin
      step(); legs("brk2fwd");
    end
    step(); expect_out("fwd2", 4'b1001, 1'b0, 1'b0);

    // Forward to reverse: both legs conflict.
    set_req(2'b10);
    step(); expect_out("rev_lat", 4'b1001, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(); expect_out("rev_dead", 4'b0000, 1'b1, 1'b0);
    end
    step(); expect_out("rev", 4'b0110, 1'b0, 1'b0);

    // Reverse to forward.
    set_req(2'b11);
    for (int i = 0; i < 5; i++) begin
      step(); legs("rev2fwd");
    end
    step(); expect_out("fwd3", 4'b1001, 1'b0, 1'b0);

    // Forward to reverse, then back to forward partway through dead time.
    set_req(2'b10);
    step(); expect_out("ovr_lat", 4'b1001, 1'b0, 1'b0);
    step(); expect_out("ovr_d0", 4'b0000, 1'b1, 1'b0);
    step(); expect_out("ovr_d1", 4'b0000, 1'b1, 1'b0);
    set_req(2'b11);
    step(); expect_out("ovr_pre", 4'b0000, 1'b1, 1'b0);
    step(); expect_out("ovr_set", 4'b0000, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(); expect_out("ovr_dead", 4'b0000, 1'b1, 1'b1);
    end
    step(); expect_out("ovr_end", 4'b1001, 1'b0, 1'b1);

    // Reset asserted during dead time.
    set_req(2'b01);
    step(); expect_out("rd_lat", 4'b1001, 1'b0, 1'b1);
    step(); expect_out("rd_dead", 4'b0001, 1'b1, 1'b1);
    reset = 1'b1;
    step(); expect_out("rd_rst", 4'b0000, 1'b0, 1'b0);
    step(); expect_out("rd_rst2", 4'b0000, 1'b0, 1'b0);
    reset = 1'b0;
    step(); expect_out("rd_rel", 4'b0000, 1'b0, 1'b0);
    step(); expect_out("rd_brk", 4'b0101, 1'b0, 1'b0);

    // Brake to drift is conflict-free.
    set_req(2'b00);
    step(); expect_out("drift_lat", 4'b0101, 1'b0, 1'b0);
    step(); expect_out("drift", 4'b0000, 1'b0, 1'b0);

    // Back-to-back drift -> forward -> drift.
    set_req(2'b11);
    step(); expect_out("b2b_0", 4'b0000, 1'b0, 1'b0);
    set_req(2'b00);
    step(); expect_out("b2b_1", 4'b1001, 1'b0, 1'b0);
    step(); expect_out("b2b_2", 4'b0000, 1'b0, 1'b0);
    step(); expect_out("b2b_3", 4'b0000, 1'b0, 1'b0);

    // Random requests including drift: shoot-through check only.
    cyc = 0;
    while (cyc < 4000) begin
      r    = 2'($urandom_range(0, 3));
      hold = int'($urandom_range(1, 8));
      set_req(r);
      for (int i = 0; i < hold; i++) begin
        step();
        legs("rnd1");
        cyc++;
      end
    end

    // Random requests without drift: every takeover is a conflict, so each
    // leg must also show the full all-off interval.
    last_a = gates[3:2];
    last_b = gates[1:0];
    off_a  = 0;
    off_b  = 0;
    cyc    = 0;
    while (cyc < 6000) begin
      r    = 2'($urandom_range(1, 3));
      hold = int'($urandom_range(1, 10));
      set_req(r);
      for (int i = 0; i < hold; i++) begin
        step();
        leg_mon("rnd2_A", gates[3], gates[2], last_a, off_a);
        leg_mon("rnd2_B", gates[1], gates[0], last_b, off_b);
        cyc++;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
